gyro_spi_reader: RTL and testbench

SPI master for the PmodGYRO (L3G4200D). It produces the x_axis/y_axis/z_axis words that the seven-segment display path consumes.
After reset it writes the configuration registers once, then burst-reads the six output registers every SAMPLE_PERIOD cycles. Each coherent 16-bit axis triple is presented with a one-cycle valid strobe.
It sits between the Pmod pins and display_controller/data_select.

---
 rtl/gyro_pkg.sv | 24 ++
 rtl/spi_byte_shifter.sv | 91 +++++++++
 rtl/gyro_spi_reader.sv | 165 ++++++++++++++++
 tb/tb_gyro_spi_reader.sv | 238 +++++++++++++++++++++++
 4 files changed

// File: rtl/gyro_pkg.sv
// Shared constants and state encoding for the L3G4200D SPI reader.
// Latency: none (definitions only).
// Backpressure: none (definitions only).
package gyro_pkg;

    localparam logic [7:0] REG_CTRL1   = 8'h20;
    localparam logic [7:0] REG_CTRL4   = 8'h23;
    localparam logic [7:0] REG_OUT_X_L = 8'h28;

    localparam logic [7:0] RD = 8'h80;
    localparam logic [7:0] MS = 8'h40;

    localparam int CFG_BYTES = 2;
    localparam int RD_BYTES  = 7;

    typedef enum logic [2:0] {
        IDLE,
        CFG1,
        CFG2,
        WAIT,
        READ
    } gyro_state_t;

endpackage

// File: rtl/spi_byte_shifter.sv
// Tick-driven SPI mode-3 byte shifter: full-duplex 8 bits, MSB first, sclk idles high.
// Latency: 16 ticks per byte; byte_end is held for the tick after the 8th rising edge.
// Backpressure: loading at the byte_end tick chains bytes seamlessly, otherwise it idles.
module spi_byte_shifter (
    input  logic       clk,
    input  logic       rst,
    input  logic       tick,
    input  logic       load,
    input  logic [7:0] tx_byte,
    input  logic       miso,
    output logic       sclk,
    output logic       mosi,
    output logic [7:0] rx_byte,
    output logic       byte_end
);
    typedef enum logic [2:0] {
        SH_IDLE,
        SH_LEAD,
        SH_LOW,
        SH_HIGH,
        SH_GAP
    } sh_state_t;

    sh_state_t  sh, sh_nxt;
    logic [6:0] tx_sr;
    logic [7:0] rx_sr;
    logic [2:0] bit_cnt;

    assign rx_byte  = rx_sr;
    assign byte_end = (sh == SH_GAP);

    always_ff @(posedge clk) begin
        if (!rst) sh <= SH_IDLE;
        else      sh <= sh_nxt;
    end

    always_comb begin
        sh_nxt = sh;
        if (tick) begin
            case (sh)
                SH_IDLE: if (load) sh_nxt = SH_LEAD;
                SH_LEAD: sh_nxt = SH_LOW;
                SH_LOW:  sh_nxt = (bit_cnt == 3'd7) ? SH_GAP : SH_HIGH;
                SH_HIGH: sh_nxt = SH_LOW;
                SH_GAP:  sh_nxt = load ? SH_LOW : SH_IDLE;
                default: sh_nxt = SH_IDLE;
            endcase
        end
    end

    // The first bit of a frame goes out with ss; later bits (including each
    // chained byte's MSB) change only on sclk falling.
    always_ff @(posedge clk) begin
        if (!rst) begin
            sclk    <= 1'b1;
            mosi    <= 1'b0;
            tx_sr   <= '0;
            rx_sr   <= '0;
            bit_cnt <= '0;
        end else if (tick) begin
            case (sh)
                SH_IDLE: if (load) begin
                    mosi    <= tx_byte[7];
                    tx_sr   <= tx_byte[6:0];
                    bit_cnt <= '0;
                end
                SH_LEAD: sclk <= 1'b0;
                SH_LOW: begin
                    sclk  <= 1'b1;
                    rx_sr <= {rx_sr[6:0], miso};
                end
                SH_HIGH: begin
                    sclk    <= 1'b0;
                    mosi    <= tx_sr[6];
                    tx_sr   <= {tx_sr[5:0], 1'b0};
                    bit_cnt <= bit_cnt + 3'd1;
                end
                SH_GAP: if (load) begin
                    sclk    <= 1'b0;
                    mosi    <= tx_byte[7];
                    tx_sr   <= tx_byte[6:0];
                    bit_cnt <= '0;
                end else begin
                    mosi <= 1'b0;
                end
                default: ;
            endcase
        end
    end

endmodule

// File: rtl/gyro_spi_reader.sv
// PmodGYRO SPI master: writes CTRL_REG1/CTRL_REG4 once, then burst-reads X/Y/Z every SAMPLE_PERIOD clocks.
// Latency: axis words and data_valid appear on the clock ss rises, 113 SCLK half-periods after ss falls.
// Backpressure: none; data_valid is a one-cycle strobe and outputs hold until the next read completes.
module gyro_spi_reader
    import gyro_pkg::*;
#(
    parameter int         CLK_DIV       = 4,
    parameter int         SAMPLE_PERIOD = 100000,
    parameter logic [7:0] CTRL1_VAL     = 8'h0F,
    parameter logic [7:0] CTRL4_VAL     = 8'h30
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        en,
    input  logic        miso,
    output logic        mosi,
    output logic        sclk,
    output logic        ss,
    output logic [15:0] x_axis,
    output logic [15:0] y_axis,
    output logic [15:0] z_axis,
    output logic        data_valid,
    output logic        busy
);
    localparam int            DW       = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
    localparam int            SW       = $clog2(SAMPLE_PERIOD);
    localparam logic [DW-1:0] DIV_LAST = DW'(CLK_DIV - 1);
    localparam logic [SW-1:0] SMP_LAST = SW'(SAMPLE_PERIOD - 1);
    localparam logic [2:0]    CFG_LAST = 3'(CFG_BYTES - 1);
    localparam logic [2:0]    RD_LAST  = 3'(RD_BYTES - 1);
    localparam logic [7:0]    RD_CMD   = RD | MS | REG_OUT_X_L;

    gyro_state_t   state, state_nxt;
    logic [DW-1:0] div;
    logic          tick;
    logic [1:0]    hi_cnt;
    logic [2:0]    byte_idx;
    logic          cfg_done;
    logic [SW-1:0] smp_cnt;
    logic [7:0]    rx_buf [0:4];
    logic          load, frame_start, frame_end, byte_next;
    logic [7:0]    ld_byte;
    logic          byte_end;
    logic [7:0]    rx_byte;

    assign tick = (div == DIV_LAST);
    assign busy = ~ss | ~cfg_done;

    spi_byte_shifter u_shifter (
        .clk      (clk),
        .rst      (rst),
        .tick     (tick),
        .load     (load),
        .tx_byte  (ld_byte),
        .miso     (miso),
        .sclk     (sclk),
        .mosi     (mosi),
        .rx_byte  (rx_byte),
        .byte_end (byte_end)
    );

    always_ff @(posedge clk) begin
        if (!rst) state <= CFG1;
        else      state <= state_nxt;
    end

    always_comb begin
        state_nxt   = state;
        load        = 1'b0;
        ld_byte     = 8'h00;
        frame_start = 1'b0;
        frame_end   = 1'b0;
        byte_next   = 1'b0;
        case (state)
            CFG1, CFG2: if (tick) begin
                if (ss && hi_cnt == 2'd2) begin
                    frame_start = 1'b1;
                    load        = 1'b1;
                    ld_byte     = (state == CFG1) ? REG_CTRL1 : REG_CTRL4;
                end else if (!ss && byte_end) begin
                    if (byte_idx == CFG_LAST) begin
                        frame_end = 1'b1;
                        state_nxt = (state == CFG1) ? CFG2 : WAIT;
                    end else begin
                        byte_next = 1'b1;
                        load      = 1'b1;
                        ld_byte   = (state == CFG1) ? CTRL1_VAL : CTRL4_VAL;
                    end
                end
            end
            WAIT: begin
                if (!en) begin
                    state_nxt = IDLE;
                end else if (tick && hi_cnt == 2'd2 && smp_cnt == SMP_LAST) begin
                    frame_start = 1'b1;
                    load        = 1'b1;
                    ld_byte     = RD_CMD;
                    state_nxt   = READ;
                end
            end
            READ: if (tick && byte_end) begin
                if (byte_idx == RD_LAST) begin
                    frame_end = 1'b1;
                    state_nxt = en ? WAIT : IDLE;
                end else begin
                    byte_next = 1'b1;
                    load      = 1'b1;
                end
            end
            IDLE: if (en) state_nxt = WAIT;
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            div        <= '0;
            ss         <= 1'b1;
            hi_cnt     <= '0;
            byte_idx   <= '0;
            cfg_done   <= 1'b0;
            smp_cnt    <= '0;
            x_axis     <= '0;
            y_axis     <= '0;
            z_axis     <= '0;
            data_valid <= 1'b0;
            for (int i = 0; i < 5; i++) rx_buf[i] <= '0;
        end else begin
            div        <= tick ? '0 : div + DW'(1);
            data_valid <= 1'b0;

            if (frame_start) begin
                ss       <= 1'b0;
                hi_cnt   <= '0;
                byte_idx <= '0;
            end else if (frame_end) begin
                ss <= 1'b1;
            end else if (tick && ss && hi_cnt != 2'd2) begin
                hi_cnt <= hi_cnt + 2'd1;
            end

            if (byte_next) byte_idx <= byte_idx + 3'd1;

            // Period is measured from ss falling of a read; leaving IDLE
            // preloads the terminal count so the read starts on the next tick.
            if (frame_start || (frame_end && state == CFG2)) smp_cnt <= '0;
            else if (state == IDLE && en)                    smp_cnt <= SMP_LAST;
            else if (smp_cnt != SMP_LAST)                    smp_cnt <= smp_cnt + SW'(1);

            if (frame_end && state == CFG2) cfg_done <= 1'b1;

            if (state == READ && byte_next && byte_idx != 3'd0)
                rx_buf[byte_idx - 3'd1] <= rx_byte;

            // ZH arrives on the same tick as ss rises, so it bypasses rx_buf.
            if (state == READ && frame_end) begin
                x_axis     <= {rx_buf[1], rx_buf[0]};
                y_axis     <= {rx_buf[3], rx_buf[2]};
                z_axis     <= {rx_byte, rx_buf[4]};
                data_valid <= 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_gyro_spi_reader.sv
// Directed bench for gyro_spi_reader with a mode-3 L3G4200D MISO model and SPI frame monitors.
module tb_gyro_spi_reader;
    localparam int CLK_DIV       = 4;
    localparam int SAMPLE_PERIOD = 2000;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        en = 1'b0;
    logic        miso = 1'b0;
    logic        mosi, sclk, ss, data_valid, busy;
    logic [15:0] x_axis, y_axis, z_axis;

    int checks = 0;
    int errors = 0;
    int cyc = 0;
    int frame_cnt = 0;
    int rise_cnt = 0;
    int dv_cnt = 0;
    int bpos;
    int fq[$];
    int rq[$];
    logic [7:0] mq[$];
    logic [7:0] mosi_sr = 8'h00;
    logic [7:0] resp [0:5];

    gyro_spi_reader #(
        .CLK_DIV       (CLK_DIV),
        .SAMPLE_PERIOD (SAMPLE_PERIOD),
        .CTRL1_VAL     (8'h0F),
        .CTRL4_VAL     (8'h30)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .en         (en),
        .miso       (miso),
        .mosi       (mosi),
        .sclk       (sclk),
        .ss         (ss),
        .x_axis     (x_axis),
        .y_axis     (y_axis),
        .z_axis     (z_axis),
        .data_valid (data_valid),
        .busy       (busy)
    );

    always #5 clk = ~clk;

    always @(posedge clk) begin
        cyc++;
        if (data_valid) dv_cnt++;
    end

    always @(negedge ss) begin
        frame_cnt++;
        rise_cnt = 0;
        fq.push_back(cyc);
    end

    always @(posedge ss) rq.push_back(rise_cnt);

    always @(posedge sclk) begin
        if (!ss) begin
            mosi_sr = {mosi_sr[6:0], mosi};
            rise_cnt++;
            if (rise_cnt % 8 == 0) mq.push_back(mosi_sr);
        end
    end

    // Slave drives the next bit on sclk falling; byte 0 is the command slot.
    always @(negedge sclk) begin
        if (!ss) begin
            bpos = rise_cnt;
            if (bpos >= 8 && bpos < 56) miso = resp[bpos / 8 - 1][7 - bpos % 8];
            else                        miso = 1'b0;
        end
    end

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h, expected %0h", tag, got, exp);
        end
    endtask

    task automatic wait_dv(input int lim, input string tag);
        int n = 0;
        @(negedge clk);
        while (data_valid !== 1'b1 && n < lim) begin
            @(negedge clk);
            n++;
        end
        chk({tag, "_dv"}, data_valid, 1'b1);
    endtask

    task automatic wait_frames(input int target, input int lim, input string tag);
        int n = 0;
        while (frame_cnt < target && n < lim) begin
            @(negedge clk);
            n++;
        end
        chk(tag, frame_cnt >= target, 1'b1);
    endtask

    task automatic wait_rises(input int target, input int lim, input string tag);
        int n = 0;
        while (rise_cnt < target && n < lim) begin
            @(negedge clk);
            n++;
        end
        chk(tag, rise_cnt >= target, 1'b1);
    endtask

    task automatic chk_axes(input string tag, input logic [15:0] ex, input logic [15:0] ey,
                            input logic [15:0] ez);
        chk({tag, "_x"}, x_axis, ex);
        chk({tag, "_y"}, y_axis, ey);
        chk({tag, "_z"}, z_axis, ez);
    endtask

    initial begin
        int n;
        int base;
        logic changed;
        logic [15:0] lx, ly, lz;

        resp = '{default: 8'h00};
        repeat (5) @(negedge clk);
        chk("rst_ss", ss, 1'b1);
        chk("rst_sclk", sclk, 1'b1);
        chk("rst_mosi", mosi, 1'b0);
        chk_axes("rst", 16'h0000, 16'h0000, 16'h0000);
        chk("rst_dv", data_valid, 1'b0);
        chk("rst_busy", busy, 1'b1);
        frame_cnt = 0;
        dv_cnt = 0;
        fq.delete();
        rq.delete();
        mq.delete();

        // Configuration with en low: two write frames, then idle.
        rst = 1'b1;
        n = 0;
        while (busy !== 1'b0 && n < 3000) begin
            @(negedge clk);
            n++;
        end
        chk("cfg_busy", busy, 1'b0);
        chk("cfg_frames", frame_cnt, 2);
        chk("cfg_bytes", {mq[0], mq[1], mq[2], mq[3]}, 32'h200F2330);
        chk("cfg_rises0", rq[0], 16);
        chk("cfg_rises1", rq[1], 16);
        repeat (2500) @(negedge clk);
        chk("idle_frames", frame_cnt, 2);
        chk("idle_sclk", sclk, 1'b1);
        chk("cfg_no_dv", dv_cnt, 0);

        // First read.
        resp = '{8'h34, 8'h12, 8'h78, 8'h56, 8'hBC, 8'h9A};
        en = 1'b1;
        wait_dv(1000, "rd1");
        chk("rd1_ss", ss, 1'b1);
        chk_axes("rd1", 16'h1234, 16'h5678, 16'h9ABC);
        chk("rd1_cmd", mq[4], 8'hE8);
        chk("rd1_mosi_data", mq[5] | mq[6] | mq[7] | mq[8] | mq[9] | mq[10], 8'h00);
        chk("rd1_rises", rq[2], 56);

        // Continuous sampling period.
        wait_dv(2500, "rd2");
        wait_dv(2500, "rd3");
        @(negedge clk);
        chk("period1", fq[3] - fq[2], 2000);
        chk("period2", fq[4] - fq[3], 2000);
        chk("dv_vs_frames", dv_cnt, frame_cnt - 2);
        chk_axes("rd3", 16'h1234, 16'h5678, 16'h9ABC);

        // Drop en during the 4th byte: frame still completes.
        resp = '{8'h11, 8'h22, 8'h33, 8'h44, 8'h55, 8'h66};
        wait_frames(6, 2500, "rd4_start");
        wait_rises(28, 400, "rd4_mid");
        en = 1'b0;
        wait_dv(500, "rd4");
        chk_axes("rd4", 16'h2211, 16'h4433, 16'h6655);
        chk("rd4_rises", rq[rq.size() - 1], 56);
        repeat (2500) @(negedge clk);
        chk("en_off_frames", frame_cnt, 6);
        chk("en_off_busy", busy, 1'b0);
        en = 1'b1;
        n = 0;
        while (ss !== 1'b0 && n < 20) begin
            @(negedge clk);
            n++;
        end
        chk("restart_latency", n <= 2 * CLK_DIV, 1'b1);

        // Reset during read byte 3 aborts at once.
        resp = '{8'hFF, 8'h7F, 8'h00, 8'h80, 8'h01, 8'h00};
        wait_rises(18, 400, "rd5_mid");
        rst = 1'b0;
        @(negedge clk);
        chk("abort_ss", ss, 1'b1);
        chk("abort_sclk", sclk, 1'b1);
        chk("abort_mosi", mosi, 1'b0);
        chk_axes("abort", 16'h0000, 16'h0000, 16'h0000);
        chk("abort_dv", data_valid, 1'b0);
        chk("abort_busy", busy, 1'b1);
        repeat (3) @(negedge clk);
        base = frame_cnt;
        mq.delete();
        rst = 1'b1;

        // Reconfiguration precedes the first read; boundary sample values.
        wait_dv(6000, "rd6");
        chk("reinit_frames", frame_cnt - base, 3);
        chk("reinit_cfg_bytes", {mq[0], mq[1], mq[2], mq[3]}, 32'h200F2330);
        chk("reinit_cmd", mq[4], 8'hE8);
        chk_axes("rd6", 16'h7FFF, 16'h8000, 16'h0001);

        lx = x_axis;
        ly = y_axis;
        lz = z_axis;
        changed = 1'b0;
        n = 0;
        @(negedge clk);
        while (data_valid !== 1'b1 && n < 2500) begin
            if (x_axis !== lx || y_axis !== ly || z_axis !== lz) changed = 1'b1;
            @(negedge clk);
            n++;
        end
        chk("hold_stable", changed, 1'b0);
        chk("rd7_dv", data_valid, 1'b1);
        chk_axes("rd7", 16'h7FFF, 16'h8000, 16'h0001);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
